conv_frame_ctrl: RTL

//  Frame sequencer for the Bayer->grey->3x3 convolution pipeline. Tracks pixel position from the

---
 rtl/conv_frame_if.sv | 23 ++
 rtl/conv_frame_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/conv_frame_if.sv
// conv_frame_if: capture-side frame/pixel strobes and conv-side sequencing outputs
// master: capture front end drives iFVAL/iDVAL/iSW and observes the sequencer outputs
// slave : conv_frame_ctrl consumes the strobes and drives position, window, pulses and state
interface conv_frame_if;
  logic        iFVAL;
  logic        iDVAL;
  logic        iSW;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oFILT_SEL;
  logic        oWIN_VALID;
  logic        oSOF;
  logic        oEOF;
  logic [1:0]  oSTATE;
  modport master (
    output iFVAL, iDVAL, iSW,
    input  oX_Cont, oY_Cont, oFILT_SEL, oWIN_VALID, oSOF, oEOF, oSTATE
  );
  modport slave (
    input  iFVAL, iDVAL, iSW,
    output oX_Cont, oY_Cont, oFILT_SEL, oWIN_VALID, oSOF, oEOF, oSTATE
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer tracking pixel position, line-buffer priming, drain and edge mask
// iCLK/iRST : clock, synchronous active-high reset
// bus.iFVAL/iDVAL/iSW : frame valid, pixel valid, requested filter select
// bus.oX_Cont/oY_Cont : pixel column/line; oFILT_SEL frame filter; oWIN_VALID delayed mask
// bus.oSOF/oEOF : frame start/end pulses; oSTATE 0 IDLE 1 PRIME 2 RUN 3 DRAIN
module conv_frame_ctrl #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 960,
  parameter int BORDER      = 10,
  parameter int PRIME_LINES = 3,
  parameter int PIPE_LAT    = 3,
  parameter int DRAIN_CYC   = 16
) (
  input logic iCLK,
  input logic iRST,
  conv_frame_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYC);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PIPE_LAT-1:0] pipe_q;
  logic fval_q, filt_q, filt_d, sof_q, sof_d, eof_q, eof_d;
  logic rise, beat, xwrap, raw;
  assign rise  = bus.iFVAL & ~fval_q;
  assign beat  = bus.iDVAL & (state_q == PRIME || state_q == RUN);
  assign xwrap = x_q == 11'(H_ACTIVE - 1);
  assign raw   = bus.iDVAL && state_q == RUN
              && x_q >= 11'(BORDER) && x_q < 11'(H_ACTIVE - BORDER)
              && y_q >= 11'(BORDER) && y_q < 11'(V_ACTIVE - BORDER);
  always_comb begin
    state_d = state_q;
    x_d     = beat ? (xwrap ? '0 : x_q + 11'd1) : x_q;
    y_d     = (beat && xwrap) ? (y_q == 11'(V_ACTIVE - 1) ? '0 : y_q + 11'd1) : y_q;
    dcnt_d  = '0;
    filt_d  = filt_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = PRIME;
        sof_d   = 1'b1;
        x_d     = '0;
        y_d     = '0;
        filt_d  = bus.iSW;
      end
      PRIME: if (!bus.iFVAL) begin
        state_d = DRAIN;
        eof_d   = 1'b1;
      end else if (beat && xwrap && y_q == 11'(PRIME_LINES - 1)) state_d = RUN;
      RUN: if (!bus.iFVAL) begin
        state_d = DRAIN;
        eof_d   = 1'b1;
      end
      DRAIN: begin
        dcnt_d  = dcnt_q + DW'(1);
        state_d = dcnt_q == DW'(DRAIN_CYC - 1) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // previous iFVAL resets high so a frame already in progress at reset release is not taken as a rise
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dcnt_q  <= '0;
      pipe_q  <= '0;
      fval_q  <= 1'b1;
      filt_q  <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dcnt_q  <= dcnt_d;
      pipe_q  <= {pipe_q[PIPE_LAT-2:0], raw};
      fval_q  <= bus.iFVAL;
      filt_q  <= filt_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end
  assign bus.oX_Cont    = x_q;
  assign bus.oY_Cont    = y_q;
  assign bus.oFILT_SEL  = filt_q;
  assign bus.oWIN_VALID = pipe_q[PIPE_LAT-1];
  assign bus.oSOF       = sof_q;
  assign bus.oEOF       = eof_q;
  assign bus.oSTATE     = state_q;
endmodule
